// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write engine: FSM states, o_status
// bit positions, the built-in init sequence and the long-wait command codes.
package lcd_pkg;

  // Write-engine states; PWRUP is only ever entered when LCD_INIT_EN is defined.
  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_e;

  // Buffered entry is {RS, byte}.
  localparam int ENTRY_W = 9;

  // o_status bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_INIT    = 3;
  localparam int STAT_OVF     = 8;
  localparam int STAT_CNT_LSB = 12;
  localparam int STAT_CNT_W   = 4;

  // Power-on sequence: 8-bit/2-line/5x8 three times, display on, clear, entry mode.
  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Commands that need the long busy time.
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT  = 8'h03;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Show-ahead synchronous FIFO buffering LCD writes ({RS, byte} entries).
// Push while full and pop while empty are ignored.
module lcd_fifo import lcd_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Pointer and occupancy next-state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the array is deliberately not reset; the pointers/count define what is valid.
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write engine: buffers LSU stores in lcd_fifo and plays each entry
// onto the LCD pins as SETUP -> EN PULSE -> HOLD -> busy WAIT.
// Optional feature macro: LCD_INIT_EN (power-up delay plus built-in init sequence).
module lcd_ctrl import lcd_pkg::*; #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETUP_CYC     = 4,
  parameter int EN_CYC        = 25,
  parameter int HOLD_CYC      = 4,
  parameter int WAIT_CYC      = 2000,
  parameter int WAIT_LONG_CYC = 82000,
  parameter int PWRUP_CYC     = 750000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_CYC), max_int(HOLD_CYC, WAIT_CYC)),
                                   max_int(WAIT_LONG_CYC, PWRUP_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

`ifdef LCD_INIT_EN
  localparam int                 IDX_W         = $clog2(INIT_LEN + 1);
  localparam state_e             ST_RST        = ST_PWRUP;
  localparam logic               INIT_DONE_RST = 1'b0;
  localparam logic [CNT_W-1:0]   CNT_RST       = CNT_W'(PWRUP_CYC - 1);
  localparam logic [31:0]        STATUS_RST    = 32'h0000_0005;
`else
  localparam state_e             ST_RST        = ST_IDLE;
  localparam logic               INIT_DONE_RST = 1'b1;
  localparam logic [CNT_W-1:0]   CNT_RST       = '0;
  localparam logic [31:0]        STATUS_RST    = 32'h0000_0004;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               init_done_q, init_done_d;
  logic               ovf_q, ovf_d;
  logic               on_q, on_d;
  logic [31:0]        status_q, status_d;
`ifdef LCD_INIT_EN
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
`endif

  logic               push, pop;
  logic [8:0]         fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic [CW-1:0]      fifo_count, count_nxt;
  logic               unused_wr_bits;

  assign unused_wr_bits = ^{i_wr_data[30:10], i_wr_data[8]};

  lcd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  ({i_wr_data[9], i_wr_data[7:0]}),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Store decode: enqueue data words, drop on full (sticky overflow), control words clear overflow.
  always_comb begin
    push  = i_wr_en && !i_wr_data[31] && !fifo_full;
    ovf_d = ovf_q;
    if (i_wr_en) begin
      if (i_wr_data[31]) ovf_d = 1'b0;
      else if (fifo_full) ovf_d = 1'b1;
    end
  end

  // Bus-write sequencer; the shared down-counter is reloaded with (duration-1) on each state entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    pop         = 1'b0;
`ifdef LCD_INIT_EN
    init_idx_d  = init_idx_q;
`endif
    case (state_q)
      ST_PWRUP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_IDLE: begin
`ifdef LCD_INIT_EN
        if (!init_done_q) begin
          rs_d       = 1'b0;
          data_d     = INIT_ROM[init_idx_q];
          init_idx_d = init_idx_q + IDX_W'(1);
          state_d    = ST_SETUP;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
        end else
`endif
        if (!fifo_empty) begin
          pop     = 1'b1;
          rs_d    = fifo_rdata[8];
          data_d  = fifo_rdata[7:0];
          state_d = ST_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          en_d    = 1'b1;
          cnt_d   = CNT_W'(EN_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          en_d    = 1'b0;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = is_long_cmd(rs_q, data_q) ? CNT_W'(WAIT_LONG_CYC - 1) : CNT_W'(WAIT_CYC - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
`ifdef LCD_INIT_EN
          if (!init_done_q && init_idx_q == IDX_W'(INIT_LEN)) init_done_d = 1'b1;
`endif
        end else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status word is built from next-cycle values so it settles one cycle after a strobe.
  always_comb begin
    count_nxt = fifo_count;
    if (push && !pop)      count_nxt = fifo_count + CW'(1);
    else if (pop && !push) count_nxt = fifo_count - CW'(1);
    status_d                                = '0;
    status_d[STAT_BUSY]                     = (state_d != ST_IDLE) || (count_nxt != '0) || !init_done_d;
    status_d[STAT_FULL]                     = (count_nxt == CW'(FIFO_DEPTH));
    status_d[STAT_EMPTY]                    = (count_nxt == '0);
    status_d[STAT_INIT]                     = init_done_d;
    status_d[STAT_OVF]                      = ovf_d;
    status_d[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(count_nxt);
  end

  assign on_d = 1'b1;

  // State, pin and status registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= CNT_RST;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= INIT_DONE_RST;
      ovf_q       <= 1'b0;
      on_q        <= 1'b0;
      status_q    <= STATUS_RST;
`ifdef LCD_INIT_EN
      init_idx_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
      on_q        <= on_d;
      status_q    <= status_d;
`ifdef LCD_INIT_EN
      init_idx_q  <= init_idx_d;
`endif
    end
  end

  assign o_status   = status_q;
  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl using small timing parameters. A transfer-level
// reference model (queue + transfer schedule arithmetic) predicts pins and status every cycle.
// Build with +define+LCD_INIT_EN to exercise the init sequence.
module tb_lcd_ctrl;

  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 2;
  localparam int W  = 5;
  localparam int WL = 20;
  localparam int P  = 10;
  localparam int D  = 4;

`ifdef LCD_INIT_EN
  localparam logic [31:0] ST_RST_EXP = 32'h0000_0005;
`else
  localparam logic [31:0] ST_RST_EXP = 32'h0000_0004;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic [31:0] o_status;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;

  lcd_ctrl #(
    .FIFO_DEPTH(D), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .WAIT_CYC(W), .WAIT_LONG_CYC(WL), .PWRUP_CYC(P)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_status(o_status), .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes, the current transfer and when the LCD is free again.
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [8:0] mq [$];
  logic [8:0] cur = '0;
  int  edge_n = 0;
  int  pop_at = -1000;
  int  free_at = 0;
  int  rom_idx = 0;
  bit  m_ovf = 0, m_on = 0, m_in_rst = 1, m_init_done = 1;
  logic [7:0] obs_q [$];
  bit  prev_en = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cost(input logic [8:0] e);
    int w;
    w = (!e[8] && (e[7:0] inside {8'h01, 8'h02, 8'h03})) ? WL : W;
    return S + E + H + w + 1;
  endfunction

  function automatic bit m_idle();
    return edge_n >= free_at - 1;
  endfunction

  function automatic bit m_settled();
    return m_idle() && mq.size() == 0 && m_init_done;
  endfunction

  task automatic model_edge(input bit wr, input logic [31:0] d, input bit rst);
    bit full_pre;
    edge_n++;
    if (rst) begin
      mq.delete();
      m_ovf = 0; cur = '0; pop_at = -1000; m_on = 0; m_in_rst = 1; rom_idx = 0;
`ifdef LCD_INIT_EN
      m_init_done = 0; free_at = edge_n + P + 1;
`else
      m_init_done = 1; free_at = edge_n + 1;
`endif
      return;
    end
    m_in_rst = 0;
    m_on = 1;
    full_pre = (mq.size() == D);
    if (edge_n >= free_at) begin
      if (!m_init_done) begin
        if (rom_idx < 6) begin
          cur = {1'b0, rom[rom_idx]}; rom_idx++;
          pop_at = edge_n; free_at = edge_n + cost(cur);
        end
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        pop_at = edge_n; free_at = edge_n + cost(cur);
      end
    end
    if (!m_init_done && rom_idx == 6 && edge_n == free_at - 1) m_init_done = 1;
    if (wr) begin
      if (d[31])         m_ovf = 0;
      else if (full_pre) m_ovf = 1;
      else               mq.push_back({d[9], d[7:0]});
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    if (m_in_rst) return ST_RST_EXP;
    s = '0;
    s[0] = !m_idle() || mq.size() > 0 || !m_init_done;
    s[1] = (mq.size() == D);
    s[2] = (mq.size() == 0);
    s[3] = m_init_done;
    s[8] = m_ovf;
    s[15:12] = 4'(mq.size());
    return s;
  endfunction

  function automatic logic exp_en();
    int since;
    since = edge_n - pop_at;
    return !m_in_rst && since >= S && since < S + E;
  endfunction

  // One clock: drive at negedge, model the edge, sample at the next negedge.
  task automatic tick(input bit wr, input logic [31:0] d, input bit rst);
    i_rst_n = ~rst; i_wr_en = wr; i_wr_data = d;
    @(posedge i_clk);
    model_edge(wr, d, rst);
    @(negedge i_clk);
    i_wr_en = 1'b0;
    check("pins", {20'h0, o_lcd_rw, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_data},
                  {20'h0, 1'b0, m_on, exp_en(), cur[8], cur[7:0]});
    check("status", o_status, exp_status());
    if (o_lcd_en && !prev_en) obs_q.push_back(o_lcd_data);
    prev_en = o_lcd_en;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && !m_settled(); i++) tick(1'b0, '0, 1'b0);
    check("drain_busy", {31'h0, o_status[0]}, 32'h0);
  endtask

  initial begin
    logic [7:0]  b2;
    logic [7:0]  six [6];
    logic [31:0] d;

    // Reset state and lcd_on release.
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
    check("rst_status", o_status, ST_RST_EXP);
    check("rst_on", {31'h0, o_lcd_on}, 32'h0);
    idle(1);
    check("on_after_rst", {31'h0, o_lcd_on}, 32'h1);

`ifdef LCD_INIT_EN
    // Init sequence with a store made during init that must only appear afterwards.
    obs_q.delete();
    idle(2);
    b2 = 8'($urandom);
    tick(1'b1, {22'h0, 1'b1, 1'b0, b2}, 1'b0);
    drain(3000);
    check("init_done", {31'h0, o_status[3]}, 32'h1);
    check("init_pulses", obs_q.size(), 7);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) check("init_byte", obs_q[i], rom[i]);
    if (obs_q.size() == 7) check("init_store_after", obs_q[6], b2);
`endif

    // Single store 0x241: fixed-offset timing from the store cycle (k=1).
    tick(1'b1, 32'h0000_0241, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      tick(1'b0, '0, 1'b0);
      check("single_en", {31'h0, o_lcd_en}, {31'h0, (k >= 4 && k <= 6) ? 1'b1 : 1'b0});
      check("single_bus", {23'h0, o_lcd_rs, o_lcd_data}, 32'h0000_0141);
      if (k == 13) check("single_busy13", {31'h0, o_status[0]}, 32'h1);
      if (k == 14) check("single_busy14", {31'h0, o_status[0]}, 32'h0);
    end

    // Clear command (long wait) with a queued data write behind it.
    b2 = 8'($urandom);
    tick(1'b1, 32'h0000_0001, 1'b0);
    tick(1'b1, {22'h0, 1'b1, 1'b0, b2}, 1'b0);
    for (int k = 3; k <= 36; k++) begin
      tick(1'b0, '0, 1'b0);
      check("long_en", {31'h0, o_lcd_en},
            {31'h0, ((k >= 4 && k <= 6) || (k >= 32 && k <= 34)) ? 1'b1 : 1'b0});
      if (k == 29) check("long_hold_q", {28'h0, o_status[15:12]}, 32'h1);
      if (k == 29) check("long_data29", {23'h0, o_lcd_rs, o_lcd_data}, 32'h0000_0001);
      if (k == 30) check("long_data30", {23'h0, o_lcd_rs, o_lcd_data}, {23'h0, 1'b1, b2});
    end
    drain(100);

    // Overflow: one write in flight, then six back-to-back stores (4 kept, 2 dropped).
    obs_q.delete();
    b2 = 8'($urandom_range(8'h20, 8'h7E));
    tick(1'b1, {22'h0, 1'b1, 1'b0, b2}, 1'b0);
    idle(1);
    for (int i = 0; i < 6; i++) begin
      six[i] = 8'($urandom_range(8'h20, 8'h7E));
      tick(1'b1, {22'h0, 1'b1, 1'b0, six[i]}, 1'b0);
    end
    check("ovf_set", {23'h0, o_status[8], 4'h0, o_status[3:0]}, 32'h0000_010B);
    check("ovf_count", {28'h0, o_status[15:12]}, 32'h4);
    tick(1'b1, 32'h8000_0000, 1'b0);
    check("ovf_clear", {31'h0, o_status[8]}, 32'h0);
    check("ovf_clear_count", {28'h0, o_status[15:12]}, 32'h4);
    drain(400);
    check("ovf_pulses", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      check("ovf_order0", obs_q[0], b2);
      for (int i = 0; i < 4; i++) check("ovf_order", obs_q[i+1], six[i]);
    end

    // Push and pop in the same cycle with two entries queued.
    tick(1'b1, 32'h0000_0241, 1'b0);
    idle(1);
    tick(1'b1, 32'h0000_0242, 1'b0);
    tick(1'b1, 32'h0000_0243, 1'b0);
    for (int i = 0; i < 100 && edge_n + 1 < free_at; i++) tick(1'b0, '0, 1'b0);
    tick(1'b1, 32'h0000_0244, 1'b0);
    check("pushpop_count", {28'h0, o_status[15:12]}, 32'h2);
    check("pushpop_bus", {23'h0, o_lcd_rs, o_lcd_data}, 32'h0000_0142);
    drain(200);

    // Randomized stores, including control words and occasional overflow.
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      d[31] = ($urandom_range(0, 7) == 0);
      tick(($urandom_range(0, 3) == 0), d, 1'b0);
    end
    drain(1000);

    // Reset asserted while EN is high.
    tick(1'b1, 32'h0000_0255, 1'b0);
    tick(1'b1, 32'h0000_0256, 1'b0);
    for (int i = 0; i < 20 && !exp_en(); i++) tick(1'b0, '0, 1'b0);
    check("pre_rst_en", {31'h0, o_lcd_en}, 32'h1);
    tick(1'b0, '0, 1'b1);
    check("rst_mid_en", {31'h0, o_lcd_en}, 32'h0);
    check("rst_mid_status", o_status, ST_RST_EXP);
    check("rst_mid_bus", {23'h0, o_lcd_rs, o_lcd_data}, 32'h0);
    tick(1'b0, '0, 1'b0);
    check("rst_mid_count", {28'h0, o_status[15:12]}, 32'h0);
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Character-LCD (HD44780-compatible) write engine. It consumes the words the core stores to the LCD I/O register through the LSU and turns each one into a correctly timed LCD bus write: RS/DATA setup, EN pulse, hold, then the busy wait. Stores are buffered in a small FIFO so the CPU never spins on LCD timing. The block sits beside the LSU output ports and drives the board LCD pins directly.

## Interface
Parameters:
- FIFO_DEPTH, 8, write-buffer entries; power of two, ≥2
- SETUP_CYC, 4, cycles RS/DATA held before EN rises
- EN_CYC, 25, cycles EN held high
- HOLD_CYC, 4, cycles RS/DATA held after EN falls
- WAIT_CYC, 2000, post-write busy time for a normal command or data byte
- WAIT_LONG_CYC, 82000, post-write busy time for Clear (0x01) and Return Home (0x02/0x03)
- PWRUP_CYC, 750000, power-on delay before the init sequence (used only with LCD_INIT_EN)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_wr_en  in  1  single-cycle store strobe from the LSU for the LCD address
- i_wr_data  in  32  store data:
  - [31] = 1 marks a control word: clears the overflow flag and is not enqueued
  - [9] = RS
  - [7:0] = byte
  - other bits are ignored
- o_status  out  32  LSU read-back:
  - [0] busy
  - [1] full
  - [2] empty
  - [3] init_done
  - [8] overflow (sticky)
  - [15:12] count
  - all other bits 0
- o_lcd_data  out  8  LCD DB[7:0]
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  tied 0; the block only writes
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power/backlight

## Operation
- FIFO entry = {RS, byte}, 9 bits. A write with [31]=0 and the FIFO not full enqueues one entry.
- A write while full is dropped and sets overflow. The entry is lost and the FIFO is unchanged.
- A write with [31]=1 clears overflow only.
- A push and a pop in the same cycle are both performed; count is unchanged.
- FSM states: PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT.
- IDLE
  - If the FIFO is non-empty: pop, latch RS/byte onto o_lcd_rs/o_lcd_data, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: EN=0 for SETUP_CYC cycles, then PULSE.
- PULSE: EN=1 for EN_CYC cycles, then HOLD.
- HOLD: EN=0 for HOLD_CYC cycles, then WAIT.
- WAIT: EN=0 for WAIT_LONG_CYC cycles if RS=0 and the byte is 0x01, 0x02 or 0x03, otherwise WAIT_CYC cycles; then IDLE.
- A single down-counter sized for the largest parameter is reloaded on every state entry.
- o_lcd_data/o_lcd_rs change only on the IDLE→SETUP transition and stay stable through WAIT.
- busy = (state ≠ IDLE) | ~empty | ~init_done.
- Reset values:
  - o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_on = 0
  - o_lcd_data = 0x00
  - FIFO empty, overflow = 0
  - o_status = 0x0000_0004 when LCD_INIT_EN is undefined
- o_lcd_on goes to 1 on the first cycle after reset release.
- Reset asserted mid-transfer: at the next edge every output takes its reset value (EN drops immediately), the FIFO is emptied, and the FSM returns to its start state.

## Timing
- For a store at edge t (FIFO empty, FSM in IDLE):
  - the entry is present at t+1 and popped at t+1
  - RS/DATA are valid from t+2
  - EN rises at t+2+SETUP_CYC and is high for exactly EN_CYC cycles
  - the FSM is back in IDLE at t+2+SETUP_CYC+EN_CYC+HOLD_CYC+WAIT_CYC
- Back-to-back queued entries: the next pop happens in the single IDLE cycle after WAIT. Every transfer costs SETUP+EN+HOLD+WAIT+1 cycles.
- Count and status bits are registered and reflect a push or pop one cycle after the strobe.

## Configuration
- LCD_INIT_EN defined:
  - After reset the FSM starts in PWRUP and waits PWRUP_CYC cycles.
  - It then issues the built-in sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0) through the normal SETUP→WAIT path, FIFO bypassed.
  - init_done is set after the last WAIT. The FIFO accepts stores during init but is not drained until init_done.
  - o_status reset value is 0x0000_0005 (busy + empty).
- LCD_INIT_EN undefined:
  - The FSM starts in IDLE, init_done is 1 from reset, and software performs initialization.

## Structure
- Package lcd_pkg holds:
  - the FSM state enum
  - o_status bit-index localparams
  - the init-sequence ROM constant and its length
  - the long-wait command codes
- Sub-module lcd_fifo: synchronous FIFO with width 9 and FIFO_DEPTH entries. It has push/pop/full/empty/count, no read latency (show-ahead), and a synchronous active-low reset on i_clk/i_rst_n.

## Test plan
All tests use small parameters: SETUP_CYC=2, EN_CYC=3, HOLD_CYC=2, WAIT_CYC=5, WAIT_LONG_CYC=20, PWRUP_CYC=10, FIFO_DEPTH=4.
- Single store of 0x0000_0241 → RS=1, DATA=0x41 from t+2; EN high for exactly 3 cycles starting at t+4; IDLE at t+14; busy clears at t+14.
- Store of 0x0000_0001 → EN pulse, then 20 WAIT cycles before IDLE; a queued second store is not popped until that wait ends.
- Six back-to-back stores → 4 accepted and 2 dropped; overflow=1 and full=1; LCD shows the first four bytes in order. A store of 0x8000_0000 then clears overflow without enqueueing.
- Store in the same cycle as a pop with count=2 → count stays 2.
- Reset asserted during PULSE → o_lcd_en=0 at the next edge; o_status equals its reset value; FIFO empty.
- With LCD_INIT_EN → 10 idle cycles, then six EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06; init_done=1 after the last wait. A store made during init appears only after that.
